// File: rtl/cpu_bus_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single memory bus, fair round-robin on ties.
// Optional grant timeout enabled by defining CPU_BUS_ARBITER_TIMEOUT_EN.
module cpu_bus_arbiter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_request,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic        i_error,
    output logic [31:0] i_rdata,
    input  logic        d_request,
    input  logic [31:0] d_addr,
    input  logic        d_write,
    input  logic [3:0]  d_byte_enable,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_error,
    output logic [31:0] d_rdata,
    output logic        m_request,
    output logic [31:0] m_addr,
    output logic        m_write,
    output logic [3:0]  m_byte_enable,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {IDLE, GNT_D, GNT_I} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    state_t state_q, state_d;
    logic   i_pend_q, i_pend_d, d_pend_q, d_pend_d;
    txn_t   i_txn_q, i_txn_d, d_txn_q, d_txn_d;
    txn_t   m_txn_q, m_txn_d;
    logic   last_d_q, last_d_d;
    logic   m_request_d, i_ack_d, d_ack_d, busy_d;
    logic [DATA_W-1:0] i_rdata_d, d_rdata_d;

    logic   i_new, d_new, i_want, d_want;
    txn_t   i_in, d_in, i_src, d_src;

`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
    localparam int unsigned TMO_W = 8;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             i_error_d, d_error_d;
    logic             tmo_hit;
    assign tmo_hit = (tmo_q == {TMO_W{1'b1}});
`endif

    // A pulse is accepted only when the port has nothing pending or in flight.
    assign i_new  = i_request && !i_pend_q && (state_q != GNT_I);
    assign d_new  = d_request && !d_pend_q && (state_q != GNT_D);
    assign i_want = i_pend_q || i_new;
    assign d_want = d_pend_q || d_new;

    assign i_in  = '{addr: i_addr, write: 1'b0, be: {BE_W{1'b1}}, wdata: {DATA_W{1'b0}}};
    assign d_in  = '{addr: d_addr, write: d_write, be: d_byte_enable, wdata: d_wdata};
    assign i_src = i_pend_q ? i_txn_q : i_in;
    assign d_src = d_pend_q ? d_txn_q : d_in;

    assign m_addr        = m_txn_q.addr;
    assign m_write       = m_txn_q.write;
    assign m_byte_enable = m_txn_q.be;
    assign m_wdata       = m_txn_q.wdata;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state, capture, grant and completion logic
    always_comb begin
        state_d     = state_q;
        i_pend_d    = i_pend_q;
        d_pend_d    = d_pend_q;
        i_txn_d     = i_txn_q;
        d_txn_d     = d_txn_q;
        m_txn_d     = m_txn_q;
        last_d_d    = last_d_q;
        m_request_d = 1'b0;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        i_rdata_d   = i_rdata;
        d_rdata_d   = d_rdata;
`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
        tmo_d       = tmo_q;
        i_error_d   = 1'b0;
        d_error_d   = 1'b0;
`endif

        if (i_new) begin
            i_pend_d = 1'b1;
            i_txn_d  = i_in;
        end
        if (d_new) begin
            d_pend_d = 1'b1;
            d_txn_d  = d_in;
        end

        case (state_q)
            IDLE: begin
                // On a tie the port that did not win last time goes first.
                if (d_want && (!i_want || !last_d_q)) begin
                    state_d     = GNT_D;
                    d_pend_d    = 1'b0;
                    m_txn_d     = d_src;
                    m_request_d = 1'b1;
                    last_d_d    = 1'b1;
`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
                    tmo_d       = '0;
`endif
                end else if (i_want) begin
                    state_d     = GNT_I;
                    i_pend_d    = 1'b0;
                    m_txn_d     = i_src;
                    m_request_d = 1'b1;
                    last_d_d    = 1'b0;
`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
                    tmo_d       = '0;
`endif
                end
            end
            GNT_D: begin
`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
                tmo_d = tmo_q + TMO_W'(1);
`endif
                if (m_ack) begin
                    state_d   = IDLE;
                    d_ack_d   = 1'b1;
                    d_rdata_d = m_rdata;
                end
`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d   = IDLE;
                    d_ack_d   = 1'b1;
                    d_error_d = 1'b1;
                    d_rdata_d = '0;
                end
`endif
            end
            GNT_I: begin
`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
                tmo_d = tmo_q + TMO_W'(1);
`endif
                if (m_ack) begin
                    state_d   = IDLE;
                    i_ack_d   = 1'b1;
                    i_rdata_d = m_rdata;
                end
`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d   = IDLE;
                    i_ack_d   = 1'b1;
                    i_error_d = 1'b1;
                    i_rdata_d = '0;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) || i_pend_d || d_pend_d;
    end

    // Pending slots, bus payload and port-side outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            i_pend_q  <= 1'b0;
            d_pend_q  <= 1'b0;
            i_txn_q   <= '0;
            d_txn_q   <= '0;
            m_txn_q   <= '0;
            last_d_q  <= 1'b0;
            m_request <= 1'b0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            busy      <= 1'b0;
        end else begin
            i_pend_q  <= i_pend_d;
            d_pend_q  <= d_pend_d;
            i_txn_q   <= i_txn_d;
            d_txn_q   <= d_txn_d;
            m_txn_q   <= m_txn_d;
            last_d_q  <= last_d_d;
            m_request <= m_request_d;
            i_ack     <= i_ack_d;
            d_ack     <= d_ack_d;
            i_rdata   <= i_rdata_d;
            d_rdata   <= d_rdata_d;
            busy      <= busy_d;
        end
    end

`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q   <= '0;
            i_error <= 1'b0;
            d_error <= 1'b0;
        end else begin
            tmo_q   <= tmo_d;
            i_error <= i_error_d;
            d_error <= d_error_d;
        end
    end
`else
    assign i_error = 1'b0;
    assign d_error = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed self-checking bench for cpu_bus_arbiter; define CPU_BUS_ARBITER_TIMEOUT_EN to cover the timeout build.
module tb_cpu_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        i_request;
    logic [31:0] i_addr;
    logic        i_ack, i_error;
    logic [31:0] i_rdata;
    logic        d_request;
    logic [31:0] d_addr;
    logic        d_write;
    logic [3:0]  d_byte_enable;
    logic [31:0] d_wdata;
    logic        d_ack, d_error;
    logic [31:0] d_rdata;
    logic        m_request;
    logic [31:0] m_addr;
    logic        m_write;
    logic [3:0]  m_byte_enable;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        busy;

    int tests = 0;
    int fails = 0;

    cpu_bus_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .i_request(i_request), .i_addr(i_addr), .i_ack(i_ack), .i_error(i_error), .i_rdata(i_rdata),
        .d_request(d_request), .d_addr(d_addr), .d_write(d_write), .d_byte_enable(d_byte_enable),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_error(d_error), .d_rdata(d_rdata),
        .m_request(m_request), .m_addr(m_addr), .m_write(m_write), .m_byte_enable(m_byte_enable),
        .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        i_request = 1'b0; i_addr = '0;
        d_request = 1'b0; d_addr = '0; d_write = 1'b0; d_byte_enable = '0; d_wdata = '0;
        m_ack = 1'b0; m_rdata = '0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        int n;
        int d_iss, i_iss;
        bit exp_d;

        do_reset();
        check("rst_m_request", 32'(m_request), 32'd0);
        check("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
        check("rst_errors", {30'd0, i_error, d_error}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_m_fields", {27'd0, m_write, m_byte_enable}, 32'd0);
        check("rst_rdata", i_rdata | d_rdata | m_wdata, 32'd0);

        // Single data read: request cycle 0, m_ack cycle 3, d_ack cycle 4.
        d_request = 1'b1; d_addr = 32'h100;
        step();
        d_request = 1'b0;
        check("rd_m_request_c1", 32'(m_request), 32'd1);
        check("rd_m_addr", m_addr, 32'h100);
        check("rd_m_write", 32'(m_write), 32'd0);
        check("rd_busy", 32'(busy), 32'd1);
        step();
        check("rd_m_request_c2", 32'(m_request), 32'd0);
        check("rd_m_addr_held", m_addr, 32'h100);
        step();
        m_ack = 1'b1; m_rdata = 32'hDEADBEEF;
        step();
        m_ack = 1'b0;
        check("rd_d_ack_c4", 32'(d_ack), 32'd1);
        check("rd_d_rdata", d_rdata, 32'hDEADBEEF);
        check("rd_i_ack", 32'(i_ack), 32'd0);
        check("rd_busy_done", 32'(busy), 32'd0);
        step();
        check("rd_d_ack_pulse", 32'(d_ack), 32'd0);
        check("rd_rdata_hold", d_rdata, 32'hDEADBEEF);

        // Tie after reset: data first, then instruction.
        do_reset();
        i_request = 1'b1; i_addr = 32'h200;
        d_request = 1'b1; d_addr = 32'h300;
        step();
        i_request = 1'b0; d_request = 1'b0;
        check("tie_first_req", 32'(m_request), 32'd1);
        check("tie_first_addr", m_addr, 32'h300);
        m_ack = 1'b1; m_rdata = 32'h11111111;
        step();
        m_ack = 1'b0;
        check("tie_d_ack", 32'(d_ack), 32'd1);
        check("tie_d_rdata", d_rdata, 32'h11111111);
        check("tie_i_not_yet", 32'(i_ack), 32'd0);
        check("tie_busy_pending", 32'(busy), 32'd1);
        step();
        check("tie_second_req", 32'(m_request), 32'd1);
        check("tie_second_addr", m_addr, 32'h200);
        m_ack = 1'b1; m_rdata = 32'h22222222;
        step();
        m_ack = 1'b0;
        check("tie_i_ack", 32'(i_ack), 32'd1);
        check("tie_i_rdata", i_rdata, 32'h22222222);
        check("tie_d_quiet", 32'(d_ack), 32'd0);

        // Fairness: both ports reissue on their ack, four transactions each.
        step();
        d_iss = 1; i_iss = 1;
        d_addr = 32'h2001; i_addr = 32'h1001;
        d_request = 1'b1; i_request = 1'b1;
        for (int t = 0; t < 8; t++) begin
            step();
            d_request = 1'b0; i_request = 1'b0;
            n = 0;
            while (!m_request && n < 8) begin
                step();
                n++;
            end
            check("fair_m_request", 32'(m_request), 32'd1);
            exp_d = (t % 2 == 0);
            check("fair_grant_addr", m_addr, exp_d ? d_addr : i_addr);
            m_ack = 1'b1; m_rdata = 32'hA0 + 32'(t);
            step();
            m_ack = 1'b0;
            check("fair_ack", 32'(exp_d ? d_ack : i_ack), 32'd1);
            check("fair_rdata", exp_d ? d_rdata : i_rdata, 32'hA0 + 32'(t));
            if (exp_d && d_iss < 4) begin
                d_iss++; d_addr = 32'h2000 + 32'(d_iss); d_request = 1'b1;
            end else if (!exp_d && i_iss < 4) begin
                i_iss++; i_addr = 32'h1000 + 32'(i_iss); i_request = 1'b1;
            end
        end
        step();
        check("fair_idle", 32'(busy), 32'd0);

        // Write, with an ignored pulse while in flight and an ignored idle m_ack.
        d_request = 1'b1; d_addr = 32'h400; d_write = 1'b1; d_byte_enable = 4'b0100; d_wdata = 32'h00AB0000;
        step();
        d_request = 1'b0;
        check("wr_m_request", 32'(m_request), 32'd1);
        check("wr_fields", {27'd0, m_write, m_byte_enable}, {27'd0, 1'b1, 4'b0100});
        check("wr_wdata", m_wdata, 32'h00AB0000);
        d_request = 1'b1; d_addr = 32'h999; d_write = 1'b0; d_byte_enable = 4'b1111; d_wdata = 32'h0;
        step();
        d_request = 1'b0;
        step();
        check("wr_hold_addr", m_addr, 32'h400);
        check("wr_hold_fields", {27'd0, m_write, m_byte_enable}, {27'd0, 1'b1, 4'b0100});
        check("wr_hold_wdata", m_wdata, 32'h00AB0000);
        m_ack = 1'b1; m_rdata = 32'h5A5A5A5A;
        step();
        m_ack = 1'b0;
        check("wr_d_ack", 32'(d_ack), 32'd1);
        check("wr_busy_after", 32'(busy), 32'd0);
        step();
        check("wr_ignored_pulse", 32'(m_request), 32'd0);
        m_ack = 1'b1; m_rdata = 32'h77777777;
        step();
        m_ack = 1'b0;
        step();
        check("idle_mack_acks", {30'd0, i_ack, d_ack}, 32'd0);
        check("idle_mack_rdata", d_rdata, 32'h5A5A5A5A);

        // Reset during GNT_I abandons the fetch.
        i_request = 1'b1; i_addr = 32'h500;
        step();
        i_request = 1'b0;
        check("rst_mid_granted", 32'(m_request), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_async", {30'd0, m_request, busy}, 32'd0);
        check("rst_mid_rdata", i_rdata | d_rdata, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        m_ack = 1'b1; m_rdata = 32'hBAD0BAD0;
        step();
        m_ack = 1'b0;
        check("rst_mid_no_ack", 32'(i_ack), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        i_request = 1'b1; i_addr = 32'h600;
        step();
        i_request = 1'b0;
        check("rst_next_addr", m_addr, 32'h600);
        m_ack = 1'b1; m_rdata = 32'h600D600D;
        step();
        m_ack = 1'b0;
        check("rst_next_ack", 32'(i_ack), 32'd1);
        check("rst_next_rdata", i_rdata, 32'h600D600D);
        step();

        // Unanswered data request.
        d_request = 1'b1; d_addr = 32'h700; d_write = 1'b0;
        step();
        d_request = 1'b0;
        check("tmo_m_request", 32'(m_request), 32'd1);
`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
        n = 0;
        while (!d_ack && n < 300) begin
            step();
            n++;
        end
        check("tmo_latency", 32'(n), 32'd256);
        check("tmo_d_error", 32'(d_error), 32'd1);
        check("tmo_d_rdata", d_rdata, 32'd0);
        step();
        check("tmo_idle", {30'd0, d_ack, busy}, 32'd0);
`else
        n = 0;
        repeat (300) begin
            step();
            if (d_ack) n++;
        end
        check("nowait_no_ack", 32'(n), 32'd0);
        check("nowait_busy", 32'(busy), 32'd1);
        m_ack = 1'b1; m_rdata = 32'h0C0FFEE0;
        step();
        m_ack = 1'b0;
        check("nowait_ack", {30'd0, d_ack, d_error}, 32'd2);
        check("nowait_rdata", d_rdata, 32'h0C0FFEE0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_bus_arbiter.md
CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 i_request  in  1  instruction fetch request, one-cycle pulse.
REQ-005 i_addr  in  32  fetch address, valid with i_request.
REQ-006 i_ack / i_error / i_rdata  out  1/1/32  fetch completion pulse, error flag, read data.
REQ-007 d_request  in  1  data request from execute stage, one-cycle pulse.
REQ-008 d_addr / d_write / d_byte_enable / d_wdata  in  32/1/4/32  data transaction fields, valid with d_request.
REQ-009 d_ack / d_error / d_rdata  out  1/1/32  data completion pulse, error flag, read data.
REQ-010 m_request  out  1  memory request pulse.
REQ-011 m_addr / m_write / m_byte_enable / m_wdata  out  32/1/4/32  memory transaction fields.
REQ-012 m_ack / m_rdata  in  1/32  memory completion pulse and read data.
REQ-013 busy  out  1  high whenever the state is not IDLE or any request is pending.

Function
REQ-014 Each port SHALL hold a pending register that captures its fields on its request pulse; instruction requests are always reads.
REQ-015 A request pulse on a port already pending or in flight SHALL be ignored.
REQ-016 States SHALL be IDLE, GNT_D and GNT_I.
REQ-017 In IDLE with one port pending, the next edge SHALL enter the matching GNT state and clear that pending bit.
REQ-018 Requests are captured at edge N and evaluated from edge N onward, so a request arriving in IDLE SHALL produce m_request in cycle N+1.
REQ-019 When both ports are pending in IDLE, the port not granted most recently SHALL win; the last-grant register resets to "instruction", so data wins the first tie.
REQ-020 Simultaneous d_request and i_request in IDLE SHALL be treated as both pending, with the REQ-019 tie-break applied.
REQ-021 m_request SHALL be high for exactly the first cycle of GNT_D or GNT_I.
REQ-022 m_addr, m_write, m_byte_enable and m_wdata SHALL hold the granted transaction for the whole GNT state.
REQ-023 On m_ack in a GNT state, the next edge SHALL:
- pulse the owning port's ack for one cycle with m_rdata registered onto its rdata and error = 0;
- return the state to IDLE.
REQ-024 Back-to-back grants: the earliest m_request after an ack SHALL occur one cycle after the port ack pulse.
REQ-025 An m_ack received in IDLE SHALL be ignored.
REQ-026 A port's new request in the cycle its ack is visible SHALL be captured normally.
REQ-027 The rdata outputs SHALL hold their value until the next ack on the same port.

Reset
REQ-028 Asserting reset_n low SHALL immediately force:
- state = IDLE;
- pending bits = 0, last-grant = instruction;
- m_request = 0, i_ack = 0, d_ack = 0, i_error = 0, d_error = 0;
- i_rdata = 0, d_rdata = 0, m_addr = 0, m_wdata = 0, m_write = 0, m_byte_enable = 0;
- busy = 0.
REQ-029 A transaction interrupted by reset SHALL be abandoned: no ack is issued, and a late m_ack is ignored per REQ-025.

Configuration
REQ-030 Macro CPU_BUS_ARBITER_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to each GNT state and increment every cycle in that state.
REQ-031 With CPU_BUS_ARBITER_TIMEOUT_EN defined, if the counter reaches 255 without m_ack, the next edge SHALL pulse the owner's ack with error = 1 and rdata = 0, then return to IDLE.
REQ-032 Macro CPU_BUS_ARBITER_TIMEOUT_EN undefined: no counter SHALL exist, GNT states SHALL wait indefinitely, and i_error and d_error SHALL be tied 0.

Verification
REQ-033 Single read: d_request with d_addr=0x100 at cycle 0, m_ack with m_rdata=0xDEADBEEF at cycle 3 -> m_request at cycle 1 with m_addr=0x100, d_ack at cycle 4 with d_rdata=0xDEADBEEF.
REQ-034 Tie: i_request and d_request in the same cycle after reset -> data granted first, instruction granted next, i_ack after d_ack.
REQ-035 Fairness: both ports reissue immediately after every ack for 4 transactions each -> grants strictly alternate D,I,D,I,...
REQ-036 Write: d_request with d_write=1, d_byte_enable=4'b0100, d_wdata=0x00AB0000 -> m_write=1, m_byte_enable=4'b0100, m_wdata=0x00AB0000 held until m_ack.
REQ-037 Reset mid-transaction: reset_n low during GNT_I, then release, then m_ack -> no i_ack and busy=0; a following i_request completes normally.
REQ-038 CPU_BUS_ARBITER_TIMEOUT_EN defined, no m_ack -> d_ack with d_error=1 and d_rdata=0 exactly 256 cycles after m_request.
